// File: rtl/mlp_act_stage.sv
// Bias add, optional ReLU and signed saturation of MAC results, feeding a show-ahead FIFO.
// Output latency is 2 edges into an empty FIFO. in_ready counts in-flight S1 so FIFO writes never fail.
module mlp_act_stage #(
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int USE_RELU   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] in_acc,
  input  logic [OUT_WIDTH-1:0] in_bias,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 stats_clr,
  output logic [15:0]          sat_count
);
  localparam int SW = ACC_WIDTH + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic signed [SW-1:0] SAT_HI = SW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

  logic                 s1_valid_q, s1_valid_d;
  logic signed [SW-1:0] s1_sum_q, s1_sum_d;
  logic                 s1_last_q, s1_last_d;
  logic [OUT_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        fifo_count_q, fifo_count_d;
  logic [15:0]          sat_count_q, sat_count_d;

  logic                 accept, wr, pop, sat_hi, sat_lo;
  logic signed [SW-1:0] r;
  logic [OUT_WIDTH-1:0] res;

  // Pessimistic: an entry still in S1 already owns a FIFO slot.
  assign in_ready  = (fifo_count_q + CW'(s1_valid_q)) < DEPTH_C;
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count_q != '0);
  assign pop       = out_valid && out_ready;
  assign wr        = s1_valid_q;
  assign out_data  = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
  assign out_last  = mem_q[rd_ptr_q][OUT_WIDTH];
  assign sat_count = sat_count_q;

  always_comb begin
    s1_valid_d = accept;
    s1_sum_d   = s1_sum_q;
    s1_last_d  = s1_last_q;
    if (accept) begin
      s1_sum_d  = $signed({in_acc[ACC_WIDTH-1], in_acc})
                + $signed({{(SW-OUT_WIDTH){in_bias[OUT_WIDTH-1]}}, in_bias});
      s1_last_d = in_last;
    end
  end

  always_comb begin
    r = s1_sum_q;
    if ((USE_RELU != 0) && s1_sum_q[SW-1]) r = '0;
    sat_hi = (r > SAT_HI);
    sat_lo = (r < SAT_LO);
    if (sat_hi)      res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sat_lo) res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else             res = r[OUT_WIDTH-1:0];
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q + CW'(wr) - CW'(pop);
    if (wr) begin
      mem_d[wr_ptr_q] = {s1_last_q, res};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    sat_count_d = sat_count_q;
    if (stats_clr)
      sat_count_d = '0;
    else if (wr && (sat_hi || sat_lo) && (sat_count_q != 16'hFFFF))
      sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_last_q    <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      sat_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sum_q     <= s1_sum_d;
      s1_last_q    <= s1_last_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      sat_count_q  <= sat_count_d;
    end
  end
endmodule
